add_seq_ctrl: RTL and testbench
===============================

// Module: add_seq_ctrl
// PURPOSE
//   Sequencer that adds two WIDTH-bit operands using one shared 4-bit ripple adder slice.
//   Processes one slice per clock, LSB first, and holds the inter-slice carry in a flop.
//   Sits between an operand producer and a result consumer with valid/ready on both sides.
//   Trades latency for area, replacing a full-width ripple chain.
// PARAMETERS
//   WIDTH    16   operand/result width; must be a multiple of SLICE_W, else elaboration error
//   NSLICES  WIDTH/SLICE_W (derived, localparam)   number of RUN cycles per operation
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operand set valid
//   in_ready   out  1      operands accepted when in_valid & in_ready at clk edge
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   carry_in   in   1      carry into bit 0
//   op_sub     in   1      subtract select (present only with ADD_SEQ_SUB_EN)
//   out_valid  out  1      result valid
//   out_ready  in   1      result consumed when out_valid & out_ready at clk edge
//   sum        out  WIDTH  result
//   carry_out  out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset values:
//   - rst asserted: state=IDLE, out_valid=0, sum=0, carry_out=0, slice counter=0, carry flop=0.
//   - in_ready = (state==IDLE) & ~rst, so in_ready is 0 while rst is high.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//   - IDLE: on in_valid&in_ready, latch a, b, carry_in (and op_sub) into regs; cnt=0; go to RUN.
//   - RUN: each edge, the slice adds opA[4cnt+:4] + opB[4cnt+:4] + carry flop.
//     The slice sum is written to sum[4cnt+:4]; the slice carry is written to the carry flop.
//     cnt increments. On the edge where cnt==NSLICES-1, carry_out <= slice carry and state goes to DONE.
//   - DONE: out_valid=1; sum and carry_out are held stable. On out_ready, go to IDLE with out_valid=0.
//   Timing:
//   - Latency: out_valid rises NSLICES edges after the accept edge (4 for WIDTH=16).
//   - Throughput: at most one operation per NSLICES+2 cycles. No overlap; in_ready=0 in RUN and DONE.
//   Boundary conditions:
//   - Changes on a, b, carry_in after acceptance have no effect; only the latched operands are used.
//   - in_valid while busy is ignored and not queued; the producer must hold it until in_ready.
//   - out_ready with out_valid=0 is ignored.
//   - rst mid-RUN or mid-DONE aborts the operation; the result is discarded and out_valid never pulses.
//   - Arithmetic is modulo 2^WIDTH; carry_out is the true bit WIDTH.
//   - WIDTH=4 (NSLICES=1): RUN lasts one cycle; all rules are unchanged.
// CONFIGURATION
//   ADD_SEQ_SUB_EN defined:
//   - op_sub port exists and is latched at acceptance.
//   - op_sub=1: B is inverted per slice and the carry flop is seeded with 1 (carry_in ignored).
//     Result is a-b mod 2^WIDTH; carry_out=1 means no borrow.
//   ADD_SEQ_SUB_EN undefined: op_sub port and inversion logic are absent; the block only adds.
// STRUCTURE
//   Package add_seq_pkg: localparam SLICE_W=4; typedef enum {IDLE,RUN,DONE} add_seq_state_t.
//   Sub-module add_slice_4bit: combinational 4-bit ripple adder (a, b, cin -> sum, cout).
//   add_seq_ctrl instantiates it exactly once. All sequencing, muxing and registers live in add_seq_ctrl.
// TESTING  (WIDTH=16 unless noted)
//   1. rst=1 mid-sim -> out_valid=0, sum=0, carry_out=0, in_ready=0 immediately; release -> in_ready=1.
//   2. a=16'h0001, b=16'h0001, cin=0 -> out_valid exactly 4 edges after accept; sum=16'h0002, carry_out=0.
//   3. a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, carry_out=1 (carry crosses all 4 slices).
//   4. out_ready=0 for 10 cycles in DONE; toggle a/b/in_valid -> sum, carry_out, out_valid=1 held; in_ready=0.
//   5. Assert rst after 2 RUN cycles; then a=16'h1234, b=16'h4321 -> no stale out_valid; sum=16'h5555.
//   6. ADD_SEQ_SUB_EN: op_sub=1, a=5, b=7 -> sum=16'hFFFE, carry_out=0; a=7, b=5 -> sum=16'h0002, carry_out=1.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the sliced sequential adder.
package add_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

endpackage

// File: rtl/add_slice_4bit.sv
// Combinational 4-bit ripple-carry adder slice shared by every step of the sequencer.
module add_slice_4bit
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit slice per clock, LSB first, valid/ready on both sides.
// Define ADD_SEQ_SUB_EN to add the op_sub port and a-b support.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// RUN   | one slice per clock, carry held in carry_q
// DONE  | result presented, waiting for out_ready
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADD_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
      $error("add_seq_ctrl: WIDTH must be a non-zero multiple of SLICE_W");
    end
  endgenerate

  add_seq_state_t state, state_next;

  logic [CNT_W-1:0]                cnt;
  logic [NSLICES-1:0][SLICE_W-1:0] op_a;
  logic [NSLICES-1:0][SLICE_W-1:0] op_b;
  logic [NSLICES-1:0][SLICE_W-1:0] sum_q;
  logic                            carry_q;
  logic                            cout_q;
`ifdef ADD_SEQ_SUB_EN
  logic                            op_sub_q;
`endif

  logic               accept;
  logic               last_slice;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               carry_seed;

  assign in_ready   = (state == IDLE) & ~rst;
  assign out_valid  = (state == DONE);
  assign accept     = in_valid & in_ready;
  assign last_slice = (cnt == LAST_CNT);
  assign sum        = sum_q;
  assign carry_out  = cout_q;

  // Subtraction is a + ~b + 1: invert B per slice and seed the carry with 1.
  always_comb begin
    slice_a    = op_a[cnt];
    slice_b    = op_b[cnt];
    carry_seed = carry_in;
`ifdef ADD_SEQ_SUB_EN
    if (op_sub_q) slice_b = ~op_b[cnt];
    if (op_sub)   carry_seed = 1'b1;
`endif
  end

  add_slice_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      op_sub_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= '0;
      op_a     <= a;
      op_b     <= b;
      carry_q  <= carry_seed;
`ifdef ADD_SEQ_SUB_EN
      op_sub_q <= op_sub;
`endif
    end else if (state == RUN) begin
      sum_q[cnt] <= slice_sum;
      carry_q    <= slice_cout;
      if (last_slice) begin
        cnt    <= '0;
        cout_q <= slice_cout;
      end else begin
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WIDTH=16): vector table, corner sequences, random ops vs model.
`timescale 1ns/1ps
module tb_add_seq_ctrl;

  localparam int W = 16;
  localparam int EXP_LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
`ifdef ADD_SEQ_SUB_EN
  logic         op_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef ADD_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic cin, input logic sub);
    if (sub) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  endfunction

  // One full transaction. Inputs are scrambled while busy; result held for hold cycles.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic cin, input logic sub, input int hold,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    int waits;
    @(negedge clk);
    a = xa; b = xb; carry_in = cin; in_valid = 1'b1;
`ifdef ADD_SEQ_SUB_EN
    op_sub = sub;
`endif
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check({tag, " accept timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (!out_valid) begin
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
        in_valid = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
        op_sub = 1'($urandom);
`endif
        @(posedge clk);
        lat++;
      end
    end while (!out_valid && lat < 20);
    check({tag, " latency"}, 32'(lat), 32'(EXP_LAT));
    check({tag, " sum"}, 32'(sum), 32'(exp_sum));
    check({tag, " carry_out"}, 32'(carry_out), 32'(exp_cout));
    for (int i = 0; i < hold; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " held sum"}, 32'(sum), 32'(exp_sum));
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W:0] m;
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0});
`ifdef ADD_SEQ_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1000, 16'h1000, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

    #2;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             (i == 1) ? 10 : 0, vecs[i].exp_sum, vecs[i].exp_cout);

    // Asynchronous reset while DONE: outputs clear immediately.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (EXP_LAT) @(negedge clk);
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst carry_out", 32'(carry_out), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst release in_ready", 32'(in_ready), 32'd1);

    // Reset after two RUN cycles: no stale result, next op is clean.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort no out_valid", 32'(out_valid), 32'd0);
    end
    run_op("post-abort", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0);

    // out_ready pulses while idle are ignored.
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    check("idle out_ready", 32'(out_valid), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      rs = 1'b0;
`ifdef ADD_SEQ_SUB_EN
      rs = 1'($urandom);
`endif
      m = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, int'($urandom_range(0, 3)), m[W-1:0], m[W]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
